// File: rtl/apb_pkg.sv
// Shared APB definitions: arbiter state encoding, default bus widths and
// the READ_WRITE polarity seen by master_bridge.
package apb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int APB_ADDR_W = 9;
  localparam int APB_DATA_W = 8;

  // master_bridge treats READ_WRITE=1 as a read
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid requester after last_grant,
// returned one-hot and as an index, plus an any-valid flag.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_valid
);

  logic found;
  int   idx;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    any_valid = |req_valid;
    found     = 1'b0;
    idx       = 0;
    // Walk from last_grant+1 around to last_grant itself
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master_bridge between NUM_REQ command
// requesters; watches the bus for completion, slave error or timeout.
module apb_req_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   transfer,
  output logic                   READ_WRITE,
  output logic [ADDR_W-1:0]      apb_write_paddr,
  output logic [ADDR_W-1:0]      apb_read_paddr,
  output logic [DATA_W-1:0]      apb_write_data,
  input  logic                   PENABLE,
  input  logic                   PREADY,
  input  logic                   PSLVERR,
  input  logic [DATA_W-1:0]      PRDATA
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  arb_state_e          state, state_nx;
  logic [IDX_W-1:0]    last_grant;
  logic [CNT_W-1:0]    wait_cnt;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                any_valid;
  logic                completion, abort, timed_out, finish, do_grant;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req_valid (req_valid),
    .last_grant(last_grant),
    .grant     (pick_oh),
    .grant_idx (pick_idx),
    .any_valid (any_valid)
  );

  // Completion beats a simultaneous error or timeout; an error beats a timeout
  always_comb begin
    completion = (state == ARB_BUSY) && PENABLE && PREADY;
    abort      = (state == ARB_BUSY) && PSLVERR && !completion;
    timed_out  = (state == ARB_BUSY) && !completion && !abort &&
                 (wait_cnt == CNT_W'(TIMEOUT - 1));
    finish     = completion || abort || timed_out;
    do_grant   = any_valid && ((state == ARB_IDLE) || completion);
    state_nx   = state;
    if (do_grant)    state_nx = ARB_BUSY;
    else if (finish) state_nx = ARB_IDLE;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= ARB_IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      wait_cnt   <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      READ_WRITE <= RW_READ;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register here samples pre-edge values.
      state     <= state_nx;
      req_ready <= do_grant ? pick_oh : '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (finish) begin
        rsp_valid <= NUM_REQ'(1) << last_grant;
        rsp_err   <= completion ? PSLVERR : 1'b1;
        if (completion && READ_WRITE == RW_READ) rsp_rdata <= PRDATA;
      end
      // The latched command only moves on a grant edge
      if (do_grant) begin
        last_grant <= pick_idx;
        READ_WRITE <= req_write[pick_idx] ? RW_WRITE : RW_READ;
        cmd_addr   <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
        cmd_wdata  <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
        wait_cnt   <= '0;
      end else if (state == ARB_BUSY && !finish) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign transfer        = (state == ARB_BUSY);
  assign apb_write_paddr = cmd_addr;
  assign apb_read_paddr  = cmd_addr;
  assign apb_write_data  = cmd_wdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a small master_bridge/slave model
// supplying PENABLE/PREADY from the arbiter's transfer output.
module tb_apb_req_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic                      PCLK = 1'b0;
  logic                      PRESETn;
  logic [NUM_REQ-1:0]        req_valid, req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready, rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err, transfer, READ_WRITE;
  logic [ADDR_W-1:0]         apb_write_paddr, apb_read_paddr;
  logic [DATA_W-1:0]         apb_write_data;
  logic                      PENABLE, PREADY, PSLVERR;
  logic [DATA_W-1:0]         PRDATA;

  int total = 0;
  int bad   = 0;

  apb_req_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK           (PCLK),
    .PRESETn        (PRESETn),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .transfer       (transfer),
    .READ_WRITE     (READ_WRITE),
    .apb_write_paddr(apb_write_paddr),
    .apb_read_paddr (apb_read_paddr),
    .apb_write_data (apb_write_data),
    .PENABLE        (PENABLE),
    .PREADY         (PREADY),
    .PSLVERR        (PSLVERR),
    .PRDATA         (PRDATA)
  );

  always #5 PCLK = ~PCLK;

  // Bridge model: IDLE -> SETUP -> ACCESS; slave inserts wait_n wait states or hangs
  typedef enum logic [1:0] {B_IDLE, B_SETUP, B_ACCESS} bphase_e;
  bphase_e bphase;
  int      acc_cnt;
  int      wait_n;
  logic    hang;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bphase  <= B_IDLE;
      acc_cnt <= 0;
    end else begin
      case (bphase)
        B_IDLE:   if (transfer) bphase <= B_SETUP;
        B_SETUP: begin
          bphase  <= transfer ? B_ACCESS : B_IDLE;
          acc_cnt <= 0;
        end
        B_ACCESS: begin
          if (PREADY) bphase <= transfer ? B_SETUP : B_IDLE;
          else        acc_cnt <= acc_cnt + 1;
        end
        default:  bphase <= B_IDLE;
      endcase
    end
  end

  assign PENABLE = (bphase == B_ACCESS);
  assign PREADY  = PENABLE && !hang && (acc_cnt >= wait_n);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    PRESETn   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    PSLVERR   = 1'b0;
    PRDATA    = '0;
    wait_n    = 0;
    hang      = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
  endtask

  task automatic wait_grant(input string tag, output int n);
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (req_ready == '0 && n < 50);
    check({tag, "_grant_seen"}, 32'(req_ready != '0), 32'h1);
  endtask

  task automatic wait_rsp(input string tag, output int n);
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (rsp_valid == '0 && n < 60);
    check({tag, "_rsp_seen"}, 32'(rsp_valid != '0), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int grants, rsps;
    logic [1:0] exp_g, outstanding;
    logic gap, moved;

    // Reset values
    do_reset();
    check("rst_transfer",  32'(transfer),        32'h0);
    check("rst_req_ready", 32'(req_ready),       32'h0);
    check("rst_rsp_valid", 32'(rsp_valid),       32'h0);
    check("rst_rsp_err",   32'(rsp_err),         32'h0);
    check("rst_rw",        32'(READ_WRITE),      32'h1);
    check("rst_waddr",     32'(apb_write_paddr), 32'h0);
    check("rst_raddr",     32'(apb_read_paddr),  32'h0);
    check("rst_wdata",     32'(apb_write_data),  32'h0);

    // Single zero-wait read from requester 0
    PRDATA        = 8'hA5;
    req_addr[8:0] = 9'h005;
    req_valid     = 2'b01;
    wait_grant("rd", n);
    check("rd_ready",    32'(req_ready),      32'h1);
    req_valid = '0;
    check("rd_transfer", 32'(transfer),       32'h1);
    check("rd_rw",       32'(READ_WRITE),     32'h1);
    check("rd_paddr",    32'(apb_read_paddr), 32'h005);
    wait_rsp("rd", n);
    check("rd_latency",  32'(n),              32'd3);
    check("rd_rsp",      32'(rsp_valid),      32'h1);
    check("rd_rdata",    32'(rsp_rdata),      32'hA5);
    check("rd_err",      32'(rsp_err),        32'h0);
    check("rd_end_xfer", 32'(transfer),       32'h0);
    @(negedge PCLK);
    check("rd_rsp_pulse", 32'(rsp_valid),     32'h0);

    // Both requesters hold writes: grants alternate, transfer stays high
    do_reset();
    req_write = 2'b11;
    req_addr  = {9'h110, 9'h010};
    req_wdata = {8'h22, 8'h11};
    req_valid = 2'b11;
    exp_g = 2'b01; outstanding = 2'b00; grants = 0; rsps = 0; gap = 1'b0; n = 0;
    while (rsps < 4 && n < 100) begin
      @(negedge PCLK);
      n++;
      if (rsp_valid != '0) begin
        rsps++;
        check($sformatf("b2b_rsp%0d", rsps),     32'(rsp_valid), 32'(outstanding));
        check($sformatf("b2b_rsp_err%0d", rsps), 32'(rsp_err),   32'h0);
      end
      if (req_ready != '0) begin
        grants++;
        check($sformatf("b2b_grant%0d", grants), 32'(req_ready), 32'(exp_g));
        check($sformatf("b2b_addr%0d", grants),  32'(apb_write_paddr),
              (exp_g == 2'b01) ? 32'h010 : 32'h110);
        check($sformatf("b2b_data%0d", grants),  32'(apb_write_data),
              (exp_g == 2'b01) ? 32'h11 : 32'h22);
        check($sformatf("b2b_rw%0d", grants),    32'(READ_WRITE), 32'h0);
        outstanding = exp_g;
        exp_g       = ~exp_g;
        if (grants == 4) req_valid = '0;
      end
      if (grants > 0 && rsps < 4 && !transfer) gap = 1'b1;
    end
    check("b2b_rsp_count", 32'(rsps),     32'd4);
    check("b2b_no_gap",    32'(gap),      32'h0);
    check("b2b_end_xfer",  32'(transfer), 32'h0);

    // Three wait states on a write: command held stable, one clean response
    do_reset();
    wait_n         = 3;
    req_write      = 2'b01;
    req_addr[8:0]  = 9'h0A3;
    req_wdata[7:0] = 8'h5C;
    req_valid      = 2'b01;
    wait_grant("ws", n);
    check("ws_ready", 32'(req_ready), 32'h1);
    req_valid = '0;
    moved = 1'b0;
    n = 0;
    while (rsp_valid == '0 && n < 50) begin
      if (apb_write_paddr !== 9'h0A3 || apb_write_data !== 8'h5C ||
          READ_WRITE !== 1'b0 || transfer !== 1'b1) moved = 1'b1;
      @(negedge PCLK);
      n++;
    end
    check("ws_stable",  32'(moved),     32'h0);
    check("ws_latency", 32'(n),         32'd6);
    check("ws_rsp",     32'(rsp_valid), 32'h1);
    check("ws_err",     32'(rsp_err),   32'h0);
    check("ws_rdata",   32'(rsp_rdata), 32'h0);

    // Slave never ready: error response 16 BUSY cycles after the grant
    do_reset();
    hang          = 1'b1;
    PRDATA        = 8'h3C;
    req_addr[8:0] = 9'h1FF;
    req_valid     = 2'b01;
    wait_grant("to", n);
    req_valid = '0;
    wait_rsp("to", n);
    check("to_latency", 32'(n),         32'd16);
    check("to_rsp",     32'(rsp_valid), 32'h1);
    check("to_err",     32'(rsp_err),   32'h1);
    check("to_rdata",   32'(rsp_rdata), 32'h0);
    check("to_xfer",    32'(transfer),  32'h0);
    @(negedge PCLK);
    check("to_rsp_pulse", 32'(rsp_valid), 32'h0);
    check("to_idle",      32'(transfer),  32'h0);

    // PSLVERR during SETUP: error abort, then re-grant of the pending requester
    do_reset();
    hang      = 1'b1;
    PRDATA    = 8'h77;
    req_addr  = {9'h120, 9'h020};
    req_valid = 2'b11;
    wait_grant("se", n);
    check("se_ready0", 32'(req_ready), 32'h1);
    req_valid = 2'b10;
    @(negedge PCLK);
    PSLVERR = 1'b1;
    @(negedge PCLK);
    PSLVERR = 1'b0;
    check("se_rsp",      32'(rsp_valid), 32'h1);
    check("se_err",      32'(rsp_err),   32'h1);
    check("se_rdata",    32'(rsp_rdata), 32'h0);
    check("se_idle",     32'(transfer),  32'h0);
    check("se_no_regnt", 32'(req_ready), 32'h0);
    @(negedge PCLK);
    check("se_ready1",   32'(req_ready),      32'h2);
    check("se_xfer1",    32'(transfer),       32'h1);
    check("se_addr1",    32'(apb_read_paddr), 32'h120);
    req_valid = '0;

    // Reset in the middle of BUSY, then requester 0 regains first priority
    do_reset();
    hang      = 1'b1;
    req_addr  = {9'h0F0, 9'h00F};
    req_valid = 2'b01;
    wait_grant("mr", n);
    check("mr_ready", 32'(req_ready), 32'h1);
    req_valid = '0;
    PRESETn   = 1'b0;
    #1;
    check("mr_xfer",  32'(transfer),  32'h0);
    check("mr_rdy",   32'(req_ready), 32'h0);
    check("mr_rsp",   32'(rsp_valid), 32'h0);
    check("mr_rw",    32'(READ_WRITE), 32'h1);
    repeat (3) @(negedge PCLK);
    check("mr_rsp_hold", 32'(rsp_valid), 32'h0);
    PRESETn   = 1'b1;
    hang      = 1'b0;
    req_valid = 2'b11;
    wait_grant("mr_post", n);
    check("mr_first", 32'(req_ready), 32'h1);
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
